// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues one data-memory bus transaction per load or
// store, stalls the pipeline while it is outstanding and formats returned load data.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_ex_mem,
  input  logic        mem_write_ex_mem,
  input  logic [2:0]  funct3_ex_mem,
  input  logic [31:0] alu_result_ex_mem,
  input  logic [31:0] store_data_ex_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] memdata,
  output logic        stall_mem,
  output logic        misaligned,
  output logic        bus_error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_reg, state_next;
  logic        req_reg, req_next;
  logic        we_reg, we_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [3:0]  wstrb_reg, wstrb_next;
  logic [31:0] memdata_reg, memdata_next;
  logic        mis_reg, mis_next;
  logic        berr_reg, berr_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [2:0]  f3_reg, f3_next;
  logic [1:0]  off_reg, off_next;

  logic        access;
  logic        is_store;
  logic        legal;
  logic        aligned;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;

  // A simultaneous read and write request is handled as a store.
  assign access   = mem_read_ex_mem | mem_write_ex_mem;
  assign is_store = mem_write_ex_mem;

  always_comb begin
    legal = 1'b0;
    case (funct3_ex_mem)
      3'd0, 3'd1, 3'd2: legal = 1'b1;
      3'd4, 3'd5:       legal = ~is_store;
      default:          legal = 1'b0;
    endcase
  end

  always_comb begin
    aligned  = 1'b0;
    st_wstrb = 4'b0000;
    case (funct3_ex_mem[1:0])
      2'd0: begin
        aligned  = 1'b1;
        st_wstrb = 4'b0001 << alu_result_ex_mem[1:0];
      end
      2'd1: begin
        aligned  = ~alu_result_ex_mem[0];
        st_wstrb = alu_result_ex_mem[1] ? 4'b1100 : 4'b0011;
      end
      2'd2: begin
        aligned  = (alu_result_ex_mem[1:0] == 2'b00);
        st_wstrb = 4'b1111;
      end
      default: begin
        aligned  = 1'b0;
        st_wstrb = 4'b0000;
      end
    endcase
  end

  // Store data is replicated across lanes so the strobes alone select the bytes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign st_wdata[8*gi +: 8] =
          (funct3_ex_mem[1:0] == 2'd0) ? store_data_ex_mem[7:0] :
          (funct3_ex_mem[1:0] == 2'd1) ? store_data_ex_mem[8*(gi%2) +: 8] :
                                         store_data_ex_mem[8*gi +: 8];
    end
  endgenerate

  assign ld_byte = dmem_rdata[{off_reg, 3'b000} +: 8];
  assign ld_half = off_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    case (f3_reg)
      3'd0:    ld_value = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_value = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_value = {24'd0, ld_byte};
      3'd5:    ld_value = {16'd0, ld_half};
      default: ld_value = dmem_rdata;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    req_next     = req_reg;
    we_next      = we_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    wstrb_next   = wstrb_reg;
    memdata_next = memdata_reg;
    mis_next     = 1'b0;
    berr_next    = 1'b0;
    cnt_next     = cnt_reg;
    f3_next      = f3_reg;
    off_next     = off_reg;

    case (state_reg)
      IDLE: begin
        if (access) begin
          f3_next  = funct3_ex_mem;
          off_next = alu_result_ex_mem[1:0];
          if (legal && aligned) begin
            req_next   = 1'b1;
            we_next    = is_store;
            addr_next  = {alu_result_ex_mem[31:2], 2'b00};
            wdata_next = is_store ? st_wdata : 32'd0;
            wstrb_next = is_store ? st_wstrb : 4'b0000;
            cnt_next   = 8'd0;
            state_next = BUSY;
          end else begin
            memdata_next = 32'd0;
            mis_next     = 1'b1;
            state_next   = DONE;
          end
        end
      end
      BUSY: begin
        if (dmem_ready) begin
          req_next     = 1'b0;
          memdata_next = we_reg ? 32'd0 : ld_value;
          cnt_next     = 8'd0;
          state_next   = DONE;
        end else if (cnt_reg == WAIT_LAST) begin
          req_next     = 1'b0;
          memdata_next = 32'd0;
          berr_next    = 1'b1;
          cnt_next     = 8'd0;
          state_next   = DONE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      req_reg     <= 1'b0;
      we_reg      <= 1'b0;
      addr_reg    <= 32'd0;
      wdata_reg   <= 32'd0;
      wstrb_reg   <= 4'b0000;
      memdata_reg <= 32'd0;
      mis_reg     <= 1'b0;
      berr_reg    <= 1'b0;
      cnt_reg     <= 8'd0;
      f3_reg      <= 3'd0;
      off_reg     <= 2'd0;
    end else begin
      state_reg   <= state_next;
      req_reg     <= req_next;
      we_reg      <= we_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      wstrb_reg   <= wstrb_next;
      memdata_reg <= memdata_next;
      mis_reg     <= mis_next;
      berr_reg    <= berr_next;
      cnt_reg     <= cnt_next;
      f3_reg      <= f3_next;
      off_reg     <= off_next;
    end
  end

  // DONE leaves stall low so MEM/WB captures memdata at the end of that cycle.
  assign stall_mem  = ((state_reg == IDLE) && access) || (state_reg == BUSY);
  assign dmem_req   = req_reg;
  assign dmem_we    = we_reg;
  assign dmem_addr  = addr_reg;
  assign dmem_wdata = wdata_reg;
  assign dmem_wstrb = wstrb_reg;
  assign memdata    = memdata_reg;
  assign misaligned = mis_reg;
  assign bus_error  = berr_reg;

endmodule
